demux_buf: RTL
==============

Name: demux_buf

Overview:
- Parametrised, flow-controlled successor to the combinational one-hot demux used in the PFU datapath.
- Routes a valid/ready input word to one of NUM_DATA output channels, selected by `sel`, or to all channels in broadcast mode.
- Each channel has its own FIFO of FIFO_DEPTH entries, so one stalled consumer does not block traffic to the other channels.
- Sits between the PFU instruction/data producer and per-patch consumers.

Parameters:
- NUM_DATA, 2, number of output channels (≥2).
- DATA_BW, 1, width of one data word in bits.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥2.
- SEL_WIDTH (localparam), `log2(NUM_DATA)`, width of `sel`.
- CNT_WIDTH (localparam), `log2(FIFO_DEPTH)+1`, width of one occupancy count.

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, input word present.
- in_ready, output, 1, input word is accepted this cycle.
- in_data, input, DATA_BW, input word.
- sel, input, SEL_WIDTH, destination channel (unicast mode).
- bcast, input, 1, 1 = write to every channel; `sel` is ignored.
- out_valid, output, NUM_DATA, per-channel FIFO non-empty.
- out_ready, input, NUM_DATA, per-channel consumer pop.
- out_data, output, DATA_BW*NUM_DATA, head word of channel I at `[I*DATA_BW +: DATA_BW]`.
- occupancy, output, CNT_WIDTH*NUM_DATA, per-channel entry count, channel I at `[I*CNT_WIDTH +: CNT_WIDTH]`.
- sel_err, output, 1, sticky flag: a unicast word with an out-of-range `sel` was dropped.

Behaviour:
- Reset (`rst`=1 at a rising edge):
  - All read/write pointers and counts go to 0.
  - `out_valid`=0, `out_data`=0, `occupancy`=0, `sel_err`=0.
  - Reset overrides a simultaneous push or pop; in-flight FIFO contents are discarded.
  - `in_ready` is 0 while `rst` is high.
- Accept: a transfer occurs when `in_valid && in_ready` at the clock edge.
- `in_ready` is combinational from registered state only; there is no path from `out_ready`:
  - Unicast, `sel` < NUM_DATA: `in_ready` = !full[sel].
  - Unicast, `sel` ≥ NUM_DATA: `in_ready`=1; the word is dropped and `sel_err` is set to 1 on the next edge. It stays 1 until reset.
  - Broadcast: `in_ready` = no channel full (AND of !full over all channels). An accepted word is written to every FIFO on the same edge.
- Full = (count == FIFO_DEPTH). Push into a full channel is impossible, because `in_ready` already excludes it. A same-cycle pop does not free a slot for a same-cycle push (no bypass).
- Pop: when `out_valid[I] && out_ready[I]` at an edge, channel I's read pointer advances. `out_ready[I]` while empty is ignored.
- Count update per channel:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, with the head advancing and the new tail written.
- Latency: a word accepted at edge N is visible on `out_valid`/`out_data` of its channel after edge N (first-word latency one cycle). There is no combinational input-to-output path.
- `out_data` is the registered FIFO head for each channel, and is 0 when the channel is empty.
- Ordering: FIFO order per channel. Across channels there is no ordering relation.
- Pointer width is `log2(FIFO_DEPTH)` and pointers wrap modulo FIFO_DEPTH; `occupancy` reflects the true count 0..FIFO_DEPTH.
- `occupancy[I]` = count register of channel I.

Test Plan:
- Reset then idle, NUM_DATA=4, DATA_BW=8, FIFO_DEPTH=4 -> `in_ready`=1 and all `out_valid`=0, `out_data`=0, `occupancy`=0, `sel_err`=0.
- Unicast 0xA5 to sel=2 at edge N -> after N, `out_valid`=4'b0100, channel 2 data=0xA5, occupancy[2]=1. Pop at N+1 -> out_valid=0 after N+1.
- Fill channel 1 with 0x11..0x14, `out_ready`=0 -> occupancy[1]=4, `in_ready`=0 for sel=1 and 1 for sel=0. Pop four times -> 0x11, 0x12, 0x13, 0x14 in order.
- Pointer wrap: 10 pushes and 10 pops interleaved on channel 3 with same-cycle push+pop -> no loss or reorder, and occupancy stays constant during overlap.
- Broadcast 0x3C with channel 0 full -> `in_ready`=0 and no channel is written. After one pop on channel 0 -> accepted, and every channel shows 0x3C at its tail.
- Out-of-range case, NUM_DATA=3, `sel`=3, data 0x77 -> `in_ready`=1, no channel written, `sel_err`=1 from the next cycle. `sel_err` stays set until rst, with rst asserted mid-fill clearing all counts.

Source files
------------

// File: rtl/demux_buf.sv
// Flow-controlled demux: routes each accepted word to one channel FIFO (or to all in broadcast).
// Every channel buffers independently, so a stalled consumer only back-pressures its own traffic.
module demux_buf #(
   parameter int NUM_DATA   = 2,
   parameter int DATA_BW    = 1,
   parameter int FIFO_DEPTH = 4,
   localparam int SEL_WIDTH = $clog2(NUM_DATA),
   localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_BW-1:0]            in_data,
   input  logic [SEL_WIDTH-1:0]          sel,
   input  logic                          bcast,
   output logic [NUM_DATA-1:0]           out_valid,
   input  logic [NUM_DATA-1:0]           out_ready,
   output logic [DATA_BW*NUM_DATA-1:0]   out_data,
   output logic [CNT_WIDTH*NUM_DATA-1:0] occupancy,
   output logic                          sel_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [SEL_WIDTH:0]   NUM_C   = (SEL_WIDTH + 1)'(NUM_DATA);

   logic [NUM_DATA-1:0] full_s;
   logic [NUM_DATA-1:0] push_s;
   logic [NUM_DATA-1:0] pop_s;
   logic                sel_ok_s;
   logic                sel_full_s;
   logic                acc_s;
   logic                sel_err_r;

   // Acceptance and push decode; in_ready depends only on registered counts, sel, bcast and rst.
   always_comb begin
      sel_ok_s   = ({1'b0, sel} < NUM_C);
      sel_full_s = 1'b0;
      for (int i = 0; i < NUM_DATA; i++) begin
         sel_full_s = sel_full_s | ((sel == SEL_WIDTH'(i)) & full_s[i]);
      end
      if (rst) begin
         in_ready = 1'b0;
      end else if (bcast) begin
         in_ready = ~(|full_s);
      end else if (sel_ok_s) begin
         in_ready = ~sel_full_s;
      end else begin
         in_ready = 1'b1;
      end
      acc_s  = in_valid & in_ready;
      push_s = {NUM_DATA{1'b0}};
      for (int i = 0; i < NUM_DATA; i++) begin
         push_s[i] = acc_s & (bcast | (sel_ok_s & (sel == SEL_WIDTH'(i))));
      end
   end

   // Sticky error: an out-of-range unicast word was accepted and dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err_r <= 1'b0;
      end else if (acc_s & ~bcast & ~sel_ok_s) begin
         sel_err_r <= 1'b1;
      end else begin
         sel_err_r <= sel_err_r;
      end
   end

   assign sel_err = sel_err_r;

   for (genvar g = 0; g < NUM_DATA; g++) begin : g_ch
      logic [DATA_BW-1:0]   mem_r [FIFO_DEPTH];
      logic [PTR_W-1:0]     wr_ptr_r;
      logic [PTR_W-1:0]     rd_ptr_r;
      logic [PTR_W-1:0]     rd_nxt_s;
      logic [CNT_WIDTH-1:0] cnt_r;
      logic [CNT_WIDTH-1:0] cnt_nxt_s;
      logic [DATA_BW-1:0]   head_r;
      logic [DATA_BW-1:0]   head_nxt_s;

      assign full_s[g] = (cnt_r == DEPTH_C);
      assign pop_s[g]  = (cnt_r != {CNT_WIDTH{1'b0}}) & out_ready[g];

      // Next count and next head; a word written into the slot that becomes head is taken from in_data.
      always_comb begin
         if (pop_s[g]) begin
            rd_nxt_s = rd_ptr_r + PTR_W'(1'b1);
         end else begin
            rd_nxt_s = rd_ptr_r;
         end
         case ({push_s[g], pop_s[g]})
            2'b10:   cnt_nxt_s = cnt_r + CNT_WIDTH'(1'b1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_WIDTH'(1'b1);
            default: cnt_nxt_s = cnt_r;
         endcase
         if (cnt_nxt_s == {CNT_WIDTH{1'b0}}) begin
            head_nxt_s = {DATA_BW{1'b0}};
         end else if (push_s[g] && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = in_data;
         end else begin
            head_nxt_s = mem_r[rd_nxt_s];
         end
      end

      // Pointer, count and registered-head state.
      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_WIDTH{1'b0}};
            head_r   <= {DATA_BW{1'b0}};
         end else begin
            wr_ptr_r <= push_s[g] ? (wr_ptr_r + PTR_W'(1'b1)) : wr_ptr_r;
            rd_ptr_r <= rd_nxt_s;
            cnt_r    <= cnt_nxt_s;
            head_r   <= head_nxt_s;
         end
      end

      // Storage array; contents need no reset because pointers and head are cleared.
      always_ff @(posedge clk) begin
         if (push_s[g]) begin
            mem_r[wr_ptr_r] <= in_data;
         end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
         end
      end

      assign out_valid[g]                        = (cnt_r != {CNT_WIDTH{1'b0}});
      assign out_data[g*DATA_BW +: DATA_BW]      = head_r;
      assign occupancy[g*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
   end

endmodule
